// File: rtl/auto_rotate_display_if.sv
// Display pin bundle for auto_rotate_display: four active-low anode enables,
// seven active-low segment drives (a..g) and an active-low decimal point.
interface auto_rotate_display_if;
  logic an3;
  logic an2;
  logic an1;
  logic an0;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;
  logic dp;

  // Display driver side
  modport master (
    output an3, an2, an1, an0,
    output a, b, c, d, e, f, g,
    output dp
  );

  // Board / observer side
  modport slave (
    input an3, an2, an1, an0,
    input a, b, c, d, e, f, g,
    input dp
  );
endinterface

// File: rtl/auto_rotate_display.sv
// Scrolling 4-digit window onto a 16-character hex message for a
// time-multiplexed common-anode seven-segment display.
// Each digit slot runs four phases: load character, decode segments
// (anodes blanked), then two cycles with the selected anode driven low.
// Optional macro DP_MARK_EN: light the decimal point on the leftmost digit
// while it shows the first message character (pointer == 0).
module auto_rotate_display #(
  parameter int unsigned ROTATE_WIDTH  = 23,
  parameter int unsigned REFRESH_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  auto_rotate_display_if.master disp
);

  localparam int unsigned CHAR_W = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;

  // Message characters 0..F packed nibble-wise, entry i at bits [4i+3:4i]
  localparam logic [16*CHAR_W-1:0] MSG_ROM = 64'hFEDC_BA98_7654_3210;

  // Active-low hex decode, bit order {a,b,c,d,e,f,g}
  function automatic logic [SEG_W-1:0] seg_decode(input logic [CHAR_W-1:0] hex);
    logic [SEG_W-1:0] seg;
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [ROTATE_WIDTH-1:0]  big_counter;
  logic [CHAR_W-1:0]        pointer;
  logic [REFRESH_WIDTH-1:0] cnt;
  logic [CHAR_W-1:0]        char_q,  char_d;
  logic [SEG_W-1:0]         seg_q,   seg_d;
  logic [AN_W-1:0]          an_q,    an_d;
  logic                     dp_q,    dp_d;
  logic [1:0]               slot;
  logic [1:0]               phase;
  logic [CHAR_W-1:0]        char_idx;
  logic                     rotate_c;
`ifdef DP_MARK_EN
  logic                     mark_q,  mark_d;
`endif

  assign slot     = cnt[REFRESH_WIDTH-1 -: 2];
  assign phase    = cnt[1:0];
  assign char_idx = pointer + CHAR_W'(slot);
  assign rotate_c = (big_counter == {ROTATE_WIDTH{1'b1}});

  // Rotation and refresh timebases; pointer steps when big_counter wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      big_counter <= '0;
      pointer     <= '0;
      cnt         <= '0;
    end else begin
      big_counter <= big_counter + ROTATE_WIDTH'(1);
      cnt         <= cnt + REFRESH_WIDTH'(1);
      if (rotate_c) begin
        pointer <= pointer + CHAR_W'(1);
      end
    end
  end

  // Per-phase next values for character, segments, anodes and dp
  always_comb begin
    char_d = char_q;
    seg_d  = seg_q;
    an_d   = 4'b1111;
    dp_d   = 1'b1;
`ifdef DP_MARK_EN
    mark_d = mark_q;
`endif
    unique case (phase)
      2'd0: begin
        char_d = MSG_ROM[{char_idx, 2'b00} +: CHAR_W];
`ifdef DP_MARK_EN
        mark_d = (pointer == '0) && (slot == 2'd0);
`endif
      end
      2'd1: begin
        seg_d = seg_decode(char_q);
      end
      default: begin
        an_d = ~(4'b1000 >> slot);
`ifdef DP_MARK_EN
        dp_d = ~mark_q;
`endif
      end
    endcase
  end

  // Display registers; the pins are driven only from these
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_q <= '0;
      seg_q  <= 7'b1111111;
      an_q   <= 4'b1111;
      dp_q   <= 1'b1;
`ifdef DP_MARK_EN
      mark_q <= 1'b0;
`endif
    end else begin
      char_q <= char_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
`ifdef DP_MARK_EN
      mark_q <= mark_d;
`endif
    end
  end

  // Pin mapping: an_q[3] is the leftmost digit, seg_q[6] is segment a
  assign disp.an3 = an_q[3];
  assign disp.an2 = an_q[2];
  assign disp.an1 = an_q[1];
  assign disp.an0 = an_q[0];
  assign disp.a   = seg_q[6];
  assign disp.b   = seg_q[5];
  assign disp.c   = seg_q[4];
  assign disp.d   = seg_q[3];
  assign disp.e   = seg_q[2];
  assign disp.f   = seg_q[1];
  assign disp.g   = seg_q[0];
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_auto_rotate_display.sv
// Directed bench for auto_rotate_display with ROTATE_WIDTH=4 so the window
// advances once per 16-cycle refresh frame.
module tb_auto_rotate_display;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  auto_rotate_display_if disp_if ();

  auto_rotate_display #(
    .ROTATE_WIDTH (4),
    .REFRESH_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .disp (disp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs_an();
    return {disp_if.an3, disp_if.an2, disp_if.an1, disp_if.an0};
  endfunction

  function automatic logic [6:0] obs_seg();
    return {disp_if.a, disp_if.b, disp_if.c, disp_if.d, disp_if.e, disp_if.f, disp_if.g};
  endfunction

  function automatic logic [6:0] hex_seg(input int h);
    case (h)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock and sample on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  // Expected pins after the n-th rising edge since reset release
  task automatic check_cycle(input int cyc);
    int c, p, s, ph, ch;
    logic [3:0] e_an;
    logic       e_dp;
    c  = (cyc - 1) % 16;
    p  = ((cyc - 1) / 16) % 16;
    s  = c / 4;
    ph = c % 4;
    ch = (p + s) % 16;
    e_an = 4'b1111;
    if (ph >= 2) begin
      case (s)
        0: e_an = 4'b0111;
        1: e_an = 4'b1011;
        2: e_an = 4'b1101;
        default: e_an = 4'b1110;
      endcase
    end
    chk("anodes", cyc, 12'(obs_an()), 12'(e_an));
    if (cyc == 1) chk("seg_hold", cyc, 12'(obs_seg()), 12'(7'b1111111));
    else if (ph != 0) chk("segments", cyc, 12'(obs_seg()), 12'(hex_seg(ch)));
    e_dp = 1'b1;
`ifdef DP_MARK_EN
    if (ph >= 2 && s == 0 && p == 0) e_dp = 1'b0;
`endif
    chk("dp", cyc, 12'(disp_if.dp), 12'(e_dp));
    chk("one_hot", cyc, 12'($countones(~obs_an()) <= 1), 12'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    n      = 0;
    reset  = 1'b1;

    // Reset window: all pins inactive
    #150;
    chk("rst_an", 0, 12'(obs_an()), 12'(4'b1111));
    chk("rst_seg", 0, 12'(obs_seg()), 12'(7'b1111111));
    chk("rst_dp", 0, 12'(disp_if.dp), 12'(1'b1));
    #100;
    reset = 1'b0;

    // Free run through all 16 pointer values and the wrap back to 0
    for (int i = 0; i < 283; i++) begin
      tick();
      check_cycle(n);
      case (n)
        3: begin
          chk("f0_an3", n, 12'(obs_an()), 12'(4'b0111));
          chk("f0_an3_seg", n, 12'(obs_seg()), 12'(7'b0000001));
        end
        7: begin
          chk("f0_an2", n, 12'(obs_an()), 12'(4'b1011));
          chk("f0_an2_seg", n, 12'(obs_seg()), 12'(7'b1001111));
        end
        19: chk("p1_an3_seg", n, 12'(obs_seg()), 12'(7'b1001111));
        31: begin
          chk("p1_an0", n, 12'(obs_an()), 12'(4'b1110));
          chk("p1_an0_seg", n, 12'(obs_seg()), 12'(7'b1001100));
        end
        243: chk("p15_an3_seg", n, 12'(obs_seg()), 12'(7'b0111000));
        247: chk("p15_an2_seg", n, 12'(obs_seg()), 12'(7'b0000001));
        259: chk("wrap_an3_seg", n, 12'(obs_seg()), 12'(7'b0000001));
        default: ;
      endcase
    end

    // Mid-frame reset while an1 is low: pins clear without a clock edge
    chk("pre_rst_an1", n, 12'(obs_an()), 12'(4'b1101));
    #2;
    reset = 1'b1;
    #1;
    chk("async_an", n, 12'(obs_an()), 12'(4'b1111));
    chk("async_seg", n, 12'(obs_seg()), 12'(7'b1111111));
    chk("async_dp", n, 12'(disp_if.dp), 12'(1'b1));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;

    // Restart from pointer 0 on an3
    for (int i = 0; i < 20; i++) begin
      tick();
      check_cycle(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
